// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } div_state_t;

  localparam int N_DEF = 4;

  // Replicated across the full quotient width on divide-by-zero.
  localparam logic DZ_Q_FILL = 1'b1;
endpackage

// File: rtl/full_Adder.sv
// One-bit full adder cell used to build the divider's subtract chain.
module full_Adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

// File: rtl/restoring_div_step.sv
// One restoring-division step: trial subtract p - d on an N+1-bit ripple chain,
// keep the difference when it does not borrow, otherwise restore p.
module restoring_div_step
  import div_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N:0]   p_i,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] rem_o,
  output logic         q_o
);
  logic [N:0]   d_inv;
  logic [N:0]   diff;
  logic [N+1:0] carry;

  assign d_inv    = ~{1'b0, d_i};
  assign carry[0] = 1'b1;

  generate
    for (genvar gi = 0; gi <= N; gi++) begin : g_sub
      full_Adder u_fa (
        .a_i(p_i[gi]),
        .b_i(d_inv[gi]),
        .c_i(carry[gi]),
        .s_o(diff[gi]),
        .c_o(carry[gi+1])
      );
    end
  endgenerate

  // With p < 2d, a non-borrowing difference always has a clear top bit.
  assign q_o   = carry[N+1] & ~diff[N];
  assign rem_o = q_o ? diff[N-1:0] : p_i[N-1:0];
endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient
// bit per clock under a START/BUSY/DONE handshake.
module seq_divider
  import div_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           START,
  input  logic [2*N-1:0] Z,
  input  logic [N-1:0]   B,
  output logic [2*N-1:0] Q,
  output logic [N-1:0]   R,
  output logic           BUSY,
  output logic           DONE,
  output logic           DZ
);
  localparam int              CNT_W    = $clog2(2 * N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * N - 1);

  div_state_t       state_q, state_d;
  logic [2*N-1:0]   dvd_q, dvd_d;
  logic [N-1:0]     dvs_q, dvs_d;
  logic [N-1:0]     rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*N-1:0]   quo_q, quo_d;
  logic [N-1:0]     res_q, res_d;
  logic             dz_q, dz_d;
  logic [N-1:0]     step_rem;
  logic             step_bit;

  restoring_div_step #(.N(N)) u_step (
    .p_i  ({rem_q, dvd_q[2*N-1]}),
    .d_i  (dvs_q),
    .rem_o(step_rem),
    .q_o  (step_bit)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      res_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      res_q   <= res_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    res_d   = res_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          if (B != '0) begin
            dvd_d   = Z;
            dvs_d   = B;
            rem_d   = '0;
            cnt_d   = CNT_LAST;
            dz_d    = 1'b0;
            state_d = RUN;
          end else begin
            quo_d   = {(2 * N){DZ_Q_FILL}};
            res_d   = '0;
            dz_d    = 1'b1;
            state_d = FIN;
          end
        end
      end
      RUN: begin
        // Quotient bits fill the dividend register from the bottom as it drains.
        dvd_d = {dvd_q[2*N-2:0], step_bit};
        rem_d = step_rem;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          quo_d   = {dvd_q[2*N-2:0], step_bit};
          res_d   = step_rem;
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign Q    = quo_q;
  assign R    = res_q;
  assign DZ   = dz_q;
  assign BUSY = (state_q == RUN);
  assign DONE = (state_q == FIN);
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table, hand sequences for
// hold/ignored-start/reset corners, random ops and an exhaustive sweep.
module tb_seq_divider;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           RST, START;
  logic [2*N-1:0] Z;
  logic [N-1:0]   B;
  logic [2*N-1:0] Q;
  logic [N-1:0]   R;
  logic           BUSY, DONE, DZ;

  int checks = 0;
  int errors = 0;

  int             dk, bn, dn;
  logic [2*N-1:0] cq;
  logic [N-1:0]   cr;
  logic           cdz;

  typedef struct {
    logic [2*N-1:0] z;
    logic [N-1:0]   b;
    logic [2*N-1:0] q;
    logic [N-1:0]   r;
    logic           dz;
  } vec_t;

  vec_t vecs[10];

  seq_divider #(.N(N)) dut (
    .CLK  (clk),
    .RST  (RST),
    .START(START),
    .Z    (Z),
    .B    (B),
    .Q    (Q),
    .R    (R),
    .BUSY (BUSY),
    .DONE (DONE),
    .DZ   (DZ)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Issue one START pulse and watch the handshake until one sample past DONE.
  task automatic do_op(input logic [2*N-1:0] z, input logic [N-1:0] b);
    dk = -1; bn = 0; dn = 0;
    @(negedge clk);
    START = 1'b1; Z = z; B = b;
    @(posedge clk);
    @(negedge clk);
    START = 1'b0;
    for (int k = 0; k < 24; k++) begin
      if (BUSY) bn++;
      if (DONE) begin
        dn++;
        if (dk < 0) begin
          dk = k; cq = Q; cr = R; cdz = DZ;
        end
      end
      if (dk >= 0 && k > dk) break;
      @(negedge clk);
    end
  endtask

  task automatic run_vec(input logic [2*N-1:0] z, input logic [N-1:0] b,
                         input logic [2*N-1:0] eq, input logic [N-1:0] er, input logic edz);
    int exp_lat;
    exp_lat = (b == 0) ? 0 : 2 * N;
    do_op(z, b);
    $display("op Z=%0d B=%0d -> Q=%0d R=%0d DZ=%0d done_at=%0d busy=%0d", z, b, cq, cr, cdz, dk, bn);
    chk("done_latency", dk, exp_lat);
    chk("busy_cycles", bn, exp_lat);
    chk("done_pulses", dn, 1);
    chk("quotient", int'(cq), int'(eq));
    chk("remainder", int'(cr), int'(er));
    chk("dz_flag", int'(cdz), int'(edz));
  endtask

  initial begin
    logic [2*N-1:0] rz, eq;
    logic [N-1:0]   rb, er;
    int             bad, lat, dcount;

    vecs[0] = '{z: 143, b: 11, q: 13,  r: 0, dz: 0};
    vecs[1] = '{z: 200, b: 15, q: 13,  r: 5, dz: 0};
    vecs[2] = '{z: 255, b: 1,  q: 255, r: 0, dz: 0};
    vecs[3] = '{z: 7,   b: 9,  q: 0,   r: 7, dz: 0};
    vecs[4] = '{z: 100, b: 0,  q: 255, r: 0, dz: 1};
    vecs[5] = '{z: 9,   b: 3,  q: 3,   r: 0, dz: 0};
    vecs[6] = '{z: 0,   b: 5,  q: 0,   r: 0, dz: 0};
    vecs[7] = '{z: 50,  b: 7,  q: 7,   r: 1, dz: 0};
    vecs[8] = '{z: 255, b: 15, q: 17,  r: 0, dz: 0};
    vecs[9] = '{z: 254, b: 13, q: 19,  r: 7, dz: 0};

    RST = 1'b1; START = 1'b0; Z = '0; B = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_q", int'(Q), 0);
    chk("reset_r", int'(R), 0);
    chk("reset_busy", int'(BUSY), 0);
    chk("reset_done", int'(DONE), 0);
    chk("reset_dz", int'(DZ), 0);
    RST = 1'b0;

    for (int i = 0; i < 10; i++)
      run_vec(vecs[i].z, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz);

    // Result holds through idle cycles.
    run_vec(8'd143, 4'd11, 8'd13, 4'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_q", int'(Q), 13);
      chk("hold_r", int'(R), 0);
    end
    $display("op hold check Q=%0d R=%0d after 5 idle cycles", Q, R);

    // START and operand changes during RUN are ignored.
    @(negedge clk);
    START = 1'b1; Z = 8'd143; B = 4'd11;
    @(posedge clk);
    lat = -1; dcount = 0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      START = (k == 3);
      if (k == 3) begin Z = 8'd20; B = 4'd2; end
      if (k == 4) begin Z = 8'd77; B = 4'd6; end
      if (DONE) begin
        dcount++;
        if (lat < 0) begin lat = k; cq = Q; cr = R; end
      end
      if (lat >= 0 && k > lat + 3) break;
    end
    START = 1'b0;
    $display("op midrun Z=143 B=11 -> Q=%0d R=%0d done_at=%0d", cq, cr, lat);
    chk("midrun_latency", lat, 2 * N);
    chk("midrun_q", int'(cq), 13);
    chk("midrun_r", int'(cr), 0);
    chk("midrun_done_pulses", dcount, 1);
    chk("midrun_not_recaptured", int'(BUSY), 0);

    // Reset mid-RUN discards the operation.
    @(negedge clk);
    START = 1'b1; Z = 8'd200; B = 4'd15;
    @(posedge clk);
    @(negedge clk);
    START = 1'b0;
    repeat (3) @(negedge clk);
    RST = 1'b1;
    @(negedge clk);
    RST = 1'b0;
    chk("midreset_busy", int'(BUSY), 0);
    chk("midreset_done", int'(DONE), 0);
    chk("midreset_q", int'(Q), 0);
    chk("midreset_r", int'(R), 0);
    dcount = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (DONE) dcount++;
    end
    $display("op midreset Z=200 B=15 -> Q=%0d R=%0d stray_done=%0d", Q, R, dcount);
    chk("midreset_no_done", dcount, 0);
    run_vec(8'd50, 4'd7, 8'd7, 4'd1, 1'b0);

    // Random operations against an arithmetic model.
    for (int i = 0; i < 100; i++) begin
      rz = 8'($urandom_range(0, 255));
      rb = 4'($urandom_range(0, 15));
      if (rb == 0) begin
        eq = 8'hFF; er = 4'd0;
      end else begin
        eq = 8'(int'(rz) / int'(rb));
        er = 4'(int'(rz) % int'(rb));
      end
      run_vec(rz, rb, eq, er, rb == 0);
    end

    // Exhaustive sweep over all non-zero divisors.
    for (int b = 1; b < 16; b++) begin
      bad = 0;
      for (int z = 0; z < 256; z++) begin
        do_op(8'(z), 4'(b));
        checks++;
        if (int'(cq) * b + int'(cr) != z || int'(cr) >= b || dn != 1 || dk != 2 * N) begin
          errors++;
          bad++;
          $display("FAIL sweep Z=%0d B=%0d: got Q=%0d R=%0d pulses=%0d lat=%0d, expected Q*B+R=Z R<B pulses=1 lat=%0d",
                   z, b, cq, cr, dn, dk, 2 * N);
        end
      end
      $display("op sweep B=%0d: 256 ops, %0d bad", b, bad);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
